ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter, the sending end of the keyboard link whose receive side feeds the direction decoder. It sends one command byte (LED set 0xED, reset 0xFF, typematic rate, and similar) to the keyboard using the standard PS/2 inhibit / request-to-send / device-clocked protocol. It drives the open-drain PS2Clk and PS2Data lines through output-enable signals and reports ACK or error. It runs in the 65 MHz pixel-clock domain beside the receiver; `busy` lets the receiver ignore line activity caused by our own transmission.

---
 rtl/ps2_host_tx.sv | 191 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, then shifts
// one byte out on device-generated clock falls and checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6500,
  parameter int TIMEOUT_CYCLES = 975000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  // Line conditioning: both pins idle high, so synchronizers reset to 1.
  logic [1:0]       clk_sync_q, data_sync_q;
  logic             clk_filt_q, clk_filt_prev_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             clk_s, data_s, fall;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_filt_prev_q & ~clk_filt_q;

  // NOTE: state elements use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q      <= 2'b11;
      data_sync_q     <= 2'b11;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      flt_cnt_q       <= '0;
    end else begin
      clk_sync_q      <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q     <= {data_sync_q[0], ps2_data_in};
      clk_filt_prev_q <= clk_filt_q;
      if (clk_s == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_s;
        flt_cnt_q  <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  logic [2:0]       state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             data_oe_q, data_oe_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             done_err_q, done_err_d;
  logic             to_expire;

  assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal assigned here gets a default first; a path that skipped
  // one would infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    data_oe_d  = data_oe_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
          bit_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          data_oe_d = 1'b1;
          to_cnt_d  = '0;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end

      S_REQ, S_SEND, S_ACK, S_WAIT_IDLE: begin
        if (to_expire) begin
          data_oe_d  = 1'b0;
          done_d     = 1'b1;
          done_err_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          case (state_q)
            S_REQ: state_d = S_SEND;
            S_SEND: begin
              if (fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = {1'b1, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'd9) state_d = S_ACK;
              end
            end
            S_ACK: begin
              if (fall) begin
                err_d   = data_s;
                state_d = S_WAIT_IDLE;
              end
            end
            default: begin
              // A stray fall after the ACK sample is deliberately ignored here.
              if (clk_filt_q && data_s) begin
                done_d     = 1'b1;
                done_err_d = err_q;
                to_cnt_d   = '0;
                state_d    = S_IDLE;
              end
            end
          endcase
        end
      end

      default: begin
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Reset releases the bus immediately: both OEs derive from reset state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      data_oe_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      data_oe_q  <= data_oe_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = ~tx_ready;
  assign ps2_clk_oe  = (state_q == S_INHIBIT);
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_error    = done_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames while a
// scoreboard of expected line bits and error flags is checked against the bus.
module tb_ps2_host_tx;

  localparam int INH  = 40;
  localparam int TO   = 3000;
  localparam int FLT  = 8;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  bit bit_q[$];
  bit err_q[$];

  // Open-drain wired-AND between host and device.
  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FLT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed event missing, expected it within bound", tag);
  endtask

  task automatic check_line_bit(input string tag);
    if (bit_q.size() == 0) fail_now({tag, "_no_expectation"});
    else check(tag, 32'(ps2_data_in), 32'(bit_q.pop_front()));
  endtask

  // Request a byte, confirm the inhibit length and the REQ state; returns at
  // the negedge of the REQ cycle.
  task automatic start_tx(input logic [7:0] data, input bit push_bits, input bit push_err,
                          input bit exp_err);
    int n;
    check("ready_before_req", 32'(tx_ready), 32'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    if (push_bits) begin
      bit_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) bit_q.push_back(data[i]);
      bit_q.push_back(~^data);
      bit_q.push_back(1'b1);
    end
    if (push_err) err_q.push_back(exp_err);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~data;
    n = 0;
    while (ps2_clk_oe === 1'b1 && n < INH + 10) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("req_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("req_data_oe", 32'(ps2_data_oe), 32'd1);
    check("req_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int limit, output int done_cyc);
    int n;
    n = 0;
    done_cyc = -1;
    while (tx_done !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (tx_done !== 1'b1) begin
      fail_now("tx_done_wait");
    end else begin
      done_cyc = cyc;
      if (err_q.size() == 0) fail_now("err_no_expectation");
      else check("tx_error", 32'(tx_error), 32'(err_q.pop_front()));
      check("done_ready", 32'(tx_ready), 32'd1);
      check("done_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      @(negedge clk);
      check("done_pulse_len", {30'd0, tx_done, tx_error}, 32'd0);
    end
  endtask

  // Device side: 11 clock falls; host bits are read just before each rise.
  task automatic run_frame(input bit ack, input bit glitch);
    int dc;
    repeat (10) @(negedge clk);
    check_line_bit("start_bit");
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i <= 10) check_line_bit($sformatf("line_bit%0d", i));
      dev_clk = 1'b1;
      if (i == 11) begin
        dev_data = 1'b1;
      end else if (glitch && i == 4) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 18) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    wait_done(200, dc);
  endtask

  initial begin
    int req_cyc;
    int done_cyc;

    #1;
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_err", {30'd0, tx_done, tx_error}, 32'd0);
    check("rst_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(tx_ready), 32'd1);

    // 0xED with ACK
    start_tx(8'hED, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0);

    // Parity corner bytes
    start_tx(8'h00, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0);
    start_tx(8'h01, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0);

    // Device withholds the ACK
    start_tx(8'hED, 1'b1, 1'b1, 1'b1);
    run_frame(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("noack_idle_err", 32'(tx_error), 32'd0);

    // Device never clocks: timeout measured from the REQ cycle
    start_tx(8'hFF, 1'b0, 1'b1, 1'b1);
    req_cyc = cyc;
    wait_done(TO + 100, done_cyc);
    check("timeout_len", 32'(done_cyc - req_cyc), 32'(TO));

    // Short glitch on the clock line mid-frame must not advance the shifter
    start_tx(8'hED, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b1);

    // Reset while in SEND with the data line pulled low
    start_tx(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_clk = 1'b0;
    repeat (25) @(negedge clk);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_oes", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("after_rst_done", 32'(tx_done), 32'd0);
    start_tx(8'hA5, 1'b1, 1'b1, 1'b0);
    run_frame(1'b1, 1'b0);

    check("queue_drained", 32'(bit_q.size() + err_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
